// File: rtl/gpu_fp_pkg.sv
// rtl/gpu_fp_pkg.sv - FP16 constants and request record shared by the fp2int arbiter slice
package gpu_fp_pkg;

    localparam int FP2INT_NREQ = 4;
    localparam int FP2INT_ID_W = $clog2(FP2INT_NREQ);

    localparam int          FP16_EXP_BIAS   = 15;
    localparam logic [4:0]  FP16_EXP_INFNAN = 5'd31;
    localparam logic [15:0] FP2INT_SAT      = 16'hFFFF;

    typedef struct packed {
        logic [15:0]            fp;
        logic [FP2INT_ID_W-1:0] id;
    } fp2int_req_t;

endpackage

// File: rtl/fp2int_conv.sv
// rtl/fp2int_conv.sv - bare FP16 -> uint16 magnitude converter (shift-ROM scale times significand)
module fp2int_conv
    import gpu_fp_pkg::*;
(
    input  logic [15:0] i_fp,
    output logic [15:0] o_int
);

    logic [4:0]  w_exp;
    logic [10:0] w_sig;
    logic [15:0] w_scale;
    logic [26:0] w_prod;

    assign w_exp = i_fp[14:10];
    assign w_sig = {|w_exp, i_fp[9:0]};

    // Scale is 2^(e-bias) for e >= bias, zero below; result keeps product bits [25:10].
    assign w_scale = (w_exp >= 5'(FP16_EXP_BIAS)) ? (16'd1 << (w_exp - 5'(FP16_EXP_BIAS))) : 16'd0;
    assign w_prod  = {16'd0, w_sig} * {11'd0, w_scale};
    assign o_int   = w_prod[25:10];

endmodule

// File: rtl/fp2int_rr_arbiter.sv
// rtl/fp2int_rr_arbiter.sv - rotating-priority grant with pointer advance on accept
module fp2int_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] i_req_valid,
    input  logic            i_can_accept,
    output logic [NREQ-1:0] o_req_ready,
    output logic [ID_W-1:0] o_gnt_id,
    output logic            o_accept
);

    logic [ID_W-1:0] r_ptr;
    logic            w_hit;
    logic [ID_W-1:0] w_gnt;
    int              w_idx;

    always_comb begin
        w_hit = 1'b0;
        w_gnt = '0;
        w_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_hit && i_req_valid[w_idx]) begin
                w_hit = 1'b1;
                w_gnt = ID_W'(w_idx);
            end
        end
    end

    assign o_req_ready = (w_hit && i_can_accept) ? (NREQ'(1) << w_gnt) : '0;
    assign o_accept    = |o_req_ready;
    assign o_gnt_id    = w_gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_accept) begin
            r_ptr <= (w_gnt == ID_W'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp2int_share_arbiter.sv
// rtl/fp2int_share_arbiter.sv - round-robin share of one FP16->uint16 converter, 2-stage pipe
module fp2int_share_arbiter
    import gpu_fp_pkg::*;
#(
    parameter int NREQ = FP2INT_NREQ,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [NREQ*16-1:0] req_fp,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [15:0]      rsp_int,
    output logic             rsp_neg,
    output logic             rsp_inf_nan,
    output logic             busy
);

    fp2int_req_t     r_s1;
    logic            r_s1_v;
    logic            r_s2_v;
    logic [ID_W-1:0] r_rsp_id;
    logic [15:0]     r_rsp_int;
    logic            r_rsp_neg;
    logic            r_rsp_inf_nan;

    logic            w_stall;
    logic            w_pipe_open;
    logic            w_accept;
    logic [ID_W-1:0] w_gnt;
    logic [15:0]     w_sel_fp;
    logic [15:0]     w_conv_int;
    logic            w_s1_inf_nan;

    assign w_stall     = r_s2_v && !rsp_ready;
    assign w_pipe_open = !r_s1_v || !w_stall;

    // Grants are suppressed while reset is held so no handshake is seen during reset.
    fp2int_rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (req_valid),
        .i_can_accept (rst_n && w_pipe_open),
        .o_req_ready  (req_ready),
        .o_gnt_id     (w_gnt),
        .o_accept     (w_accept)
    );

    assign w_sel_fp = req_fp[{w_gnt, 4'b0000} +: 16];

    fp2int_conv u_conv (
        .i_fp  (r_s1.fp),
        .o_int (w_conv_int)
    );

    assign w_s1_inf_nan = (r_s1.fp[14:10] == FP16_EXP_INFNAN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1          <= '0;
            r_s1_v        <= 1'b0;
            r_s2_v        <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_int     <= '0;
            r_rsp_neg     <= 1'b0;
            r_rsp_inf_nan <= 1'b0;
        end else begin
            if (w_pipe_open) begin
                r_s1_v <= w_accept;
                if (w_accept) begin
                    r_s1.fp <= w_sel_fp;
                    r_s1.id <= w_gnt;
                end
            end
            // S2 only reloads with real data so response fields stay quiet between results.
            if (!w_stall) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_rsp_id      <= r_s1.id;
                    r_rsp_int     <= w_s1_inf_nan ? FP2INT_SAT : w_conv_int;
                    r_rsp_neg     <= r_s1.fp[15];
                    r_rsp_inf_nan <= w_s1_inf_nan;
                end
            end
        end
    end

    assign rsp_valid   = r_s2_v;
    assign rsp_id      = r_rsp_id;
    assign rsp_int     = r_rsp_int;
    assign rsp_neg     = r_rsp_neg;
    assign rsp_inf_nan = r_rsp_inf_nan;
    assign busy        = r_s1_v | r_s2_v;

endmodule

// File: tb/tb_fp2int_share_arbiter.sv
// tb/tb_fp2int_share_arbiter.sv - scoreboard bench for fp2int_share_arbiter
module tb_fp2int_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_fp;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_int;
    logic        rsp_neg;
    logic        rsp_inf_nan;
    logic        busy;

    always #5 clk = ~clk;

    fp2int_share_arbiter #(.NREQ(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fp      (req_fp),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_int     (rsp_int),
        .rsp_neg     (rsp_neg),
        .rsp_inf_nan (rsp_inf_nan),
        .busy        (busy)
    );

    typedef struct {
        int id;
        int iv;
        bit neg;
        bit inf;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_ptr    = 0;
    int          n_acc    = 0;
    logic [15:0] fpa[4];
    logic [3:0]  last_ready;

    task automatic check(input string name, input longint act, input longint expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic exp_t model_conv(input logic [15:0] fp, input int id);
        exp_t r;
        int   e;
        int   m;
        e     = int'(fp[14:10]);
        m     = int'(fp[9:0]);
        r.id  = id;
        r.neg = fp[15];
        r.inf = (e == 31);
        if (e == 31)      r.iv = 65535;
        else if (e < 15)  r.iv = 0;
        else              r.iv = ((1024 + m) * (1 << (e - 15))) / 1024;
        return r;
    endfunction

    function automatic int model_grant(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] v, input logic rr);
        int g;
        @(negedge clk);
        req_valid = v;
        rsp_ready = rr;
        req_fp    = {fpa[3], fpa[2], fpa[1], fpa[0]};
        #1;
        last_ready = req_ready;
        if (rst_n && req_ready != 4'd0) begin
            g = model_grant(v);
            check("grant_onehot", req_ready, (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                q.push_back(model_conv(fpa[g], g));
                m_ptr = (g + 1) % 4;
            end
            n_acc++;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 20) begin
            step(4'd0, 1'b1);
            budget++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    initial begin : monitor
        bit         hold;
        logic [19:0] snap;
        exp_t       e;
        hold = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("hold_valid", rsp_valid, 1);
                    check("hold_fields", {rsp_id, rsp_int, rsp_neg, rsp_inf_nan}, snap);
                end
                if (rsp_valid && rsp_ready) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got id %0d int 0x%0h with empty scoreboard", rsp_id, rsp_int);
                    end else begin
                        e = q.pop_front();
                        check("rsp_id", rsp_id, e.id);
                        check("rsp_int", rsp_int, e.iv);
                        check("rsp_neg", rsp_neg, e.neg);
                        check("rsp_inf_nan", rsp_inf_nan, e.inf);
                    end
                end
                hold = rsp_valid && !rsp_ready;
                snap = {rsp_id, rsp_int, rsp_neg, rsp_inf_nan};
            end
        end
    end

    logic [15:0] dir_fp[7] = '{16'h4500, 16'hC500, 16'h3BFF, 16'h7BFF, 16'h7C00, 16'h7E00, 16'h0001};

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) fpa[i] = 16'($urandom);
        req_fp    = {fpa[3], fpa[2], fpa[1], fpa[0]};

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("rst_req_ready", req_ready, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_busy", busy, 0);
        end
        rst_n     = 1'b1;
        req_valid = 4'd0;

        for (int t = 0; t < 7; t++) begin
            fpa[0] = dir_fp[t];
            step(4'b0001, 1'b1);
            step(4'b0000, 1'b1);
            check("lat_first_edge", rsp_valid, 0);
            check("lat_busy", busy, 1);
            step(4'b0000, 1'b1);
            check("lat_second_edge", rsp_valid, 1);
        end
        drain();

        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
            step(4'hF, 1'b1);
        end
        check("rr_throughput", n_acc, 12);

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
            step(4'hF, 1'b0);
            check("bp_req_ready", last_ready, 0);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
            step(4'hF, 1'b1);
        end
        drain();

        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
            step(4'($urandom), ($urandom_range(0, 3) != 0));
        end
        drain();

        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
            step(4'hF, 1'b0);
        end
        check("mid_busy_before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        q.delete();
        m_ptr = 0;
        rst_n     = 1'b1;
        req_valid = 4'd0;
        for (int j = 0; j < 4; j++) fpa[j] = 16'($urandom);
        step(4'b1110, 1'b1);
        check("post_rst_grant", last_ready, 4'b0010);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
